// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file: register 0 is a read-only ID, the rest are R/W.
// Optional byte-strobe writes are enabled by defining APB_SLV_PSTRB_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a setup phase
// ST_WAIT   | counting down wait states, pready low
// ST_ACCESS | response presented with pready high, waiting for completion
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_dec, rd_lat, wdata;
    logic                  unused_ok;

    // Wrap-around of the subtraction makes addresses below the base fall out of range too
    assign off     = paddr - BASE_ADDR;
    assign dec_idx = off[IDX_W+1:2];
    assign dec_err = (paddr[1:0] != 2'b00) || (off >= WIN_BYTES) || (pwrite && dec_idx == '0);
    assign rd_dec  = (dec_idx == '0) ? ID_VALUE : regs_q[dec_idx];
    assign rd_lat  = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
    assign unused_ok = ^{pprot, pstrb};

    always_comb begin
`ifdef APB_SLV_PSTRB_EN
        wdata = regs_q[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (pstrb[b]) wdata[8*b +: 8] = pwdata[8*b +: 8];
        end
`else
        wdata = pwdata;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        wr_d      = wr_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        regs_d    = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    idx_d = dec_idx;
                    err_d = dec_err;
                    wr_d  = pwrite;
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = dec_err;
                        prdata_d  = (dec_err || pwrite) ? '0 : rd_dec;
                        state_d   = ST_ACCESS;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (err_q || wr_q) ? '0 : rd_lat;
                        state_d   = ST_ACCESS;
                    end
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (!psel || (penable && pready_q)) begin
                    if (psel && wr_q && !err_q) regs_d[idx_q] = wdata;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
endmodule
